// File: rtl/mdl_stopreq_seq_pkg.sv
// rtl/mdl_stopreq_seq_pkg.sv - shared state enum and rotator slot constants for the stop-request sequencer
package mdl_stopreq_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STOPRQ = 2'd2,
        RESYNC = 2'd3
    } seq_state_t;

    localparam int ROT8_W           = 8;
    localparam int ROT20_W          = 20;
    localparam int ROT8_SAMPLE_SLOT = 5;
    localparam int ROT8_LAP_SLOT    = 7;
    localparam int ROT20_LAST_SLOT  = 19;

endpackage

// File: rtl/mdl_stopreq_seq_if.sv
// rtl/mdl_stopreq_seq_if.sv - link between the stop-request sequencer (master) and the supervisor (slave)
interface mdl_stopreq_seq_if;
    import mdl_stopreq_seq_pkg::*;

    logic                 o_CLK2M_STOPRQ0_n;
    logic                 o_CLK2M_STOPRQ1_n;
    logic                 i_CLK2M_STOP_n;
    logic                 i_SYS_RUN_FLAG;
    logic                 i_CLK2M_PCEN_n;
    logic [ROT8_W-1:0]    i_ROT8;
    logic [ROT20_W-1:0]   i_ROT20_n;

    modport master (
        output o_CLK2M_STOPRQ0_n, o_CLK2M_STOPRQ1_n,
        input  i_CLK2M_STOP_n, i_SYS_RUN_FLAG, i_CLK2M_PCEN_n, i_ROT8, i_ROT20_n
    );

    modport slave (
        input  o_CLK2M_STOPRQ0_n, o_CLK2M_STOPRQ1_n,
        output i_CLK2M_STOP_n, i_SYS_RUN_FLAG, i_CLK2M_PCEN_n, i_ROT8, i_ROT20_n
    );

endinterface

// File: rtl/mdl_stopreq_seq_frame_cntr.sv
// rtl/mdl_stopreq_seq_frame_cntr.sv - loadable frame down-counter; a loaded 0 counts 2^W wraps
module submdl_frame_cntr #(
    parameter int W = 8
) (
    input  logic         i_MCLK,
    input  logic         i_MRST_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_last
);

    logic [W-1:0] cnt_q;

    // Decrementing a stored 0 rolls to all-ones, which gives the 0-means-2^W rule for free.
    always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= i_load_val;
        end else if (i_dec) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign o_last = (cnt_q == W'(1));

endmodule

// File: rtl/mdl_stopreq_seq.sv
// rtl/mdl_stopreq_seq.sv - frame-counted CLK2M stop requester; STOPREQ_WATCHDOG_EN adds the STOPRQ lap watchdog
module mdl_stopreq_seq
    import mdl_stopreq_seq_pkg::*;
#(
    parameter int FRAME_W      = 8,
    parameter int TIMEOUT_LAPS = 16
) (
    input  logic                  i_MCLK,
    input  logic                  i_MRST_n,
    input  logic                  i_CLK4M_PCEN_n,
    mdl_stopreq_seq_if.master     sup,
    input  logic                  i_START,
    input  logic [FRAME_W-1:0]    i_FRAMES,
    input  logic                  i_ABORT,
    output logic                  o_BUSY,
    output logic                  o_DONE,
    output logic                  o_TIMEOUT
);

    seq_state_t state_q;
    logic       rq0_n_q, rq1_n_q, busy_q, done_q, seen_low_q;
    logic       en, wrap, accept, dec, last, final_wrap;
    logic       unused_ok;

    assign en         = !i_CLK4M_PCEN_n;
    assign wrap       = en && !sup.i_CLK2M_PCEN_n && !sup.i_ROT20_n[ROT20_LAST_SLOT];
    assign accept     = en && (state_q == IDLE) && i_START && sup.i_SYS_RUN_FLAG;
    assign dec        = wrap && (state_q == RUN);
    assign final_wrap = dec && last;
    assign unused_ok  = ^{sup.i_ROT8, sup.i_ROT20_n};

    submdl_frame_cntr #(.W(FRAME_W)) u_frame_cntr (
        .i_MCLK     (i_MCLK),
        .i_MRST_n   (i_MRST_n),
        .i_load     (accept),
        .i_load_val (i_FRAMES),
        .i_dec      (dec),
        .o_last     (last)
    );

`ifdef STOPREQ_WATCHDOG_EN
    localparam int LAP_W = $clog2(TIMEOUT_LAPS + 1);
    logic [LAP_W-1:0] lap_q;
    logic             timeout_q;
`endif

    always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            state_q    <= IDLE;
            rq0_n_q    <= 1'b1;
            rq1_n_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            seen_low_q <= 1'b0;
`ifdef STOPREQ_WATCHDOG_EN
            lap_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else if (en) begin
            done_q <= 1'b0;
`ifdef STOPREQ_WATCHDOG_EN
            if (state_q != STOPRQ) lap_q <= '0;
`endif
            case (state_q)
                IDLE: begin
                    if (i_START && sup.i_SYS_RUN_FLAG) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
`ifdef STOPREQ_WATCHDOG_EN
                        timeout_q <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    // Abort outranks a coincident final wrap so the abort line is the one raised.
                    if (i_ABORT) begin
                        rq1_n_q <= 1'b0;
                        state_q <= STOPRQ;
                    end else if (final_wrap) begin
                        rq0_n_q <= 1'b0;
                        state_q <= STOPRQ;
                    end
                end
                STOPRQ: begin
                    if (!sup.i_CLK2M_STOP_n) begin
                        rq0_n_q    <= 1'b1;
                        rq1_n_q    <= 1'b1;
                        seen_low_q <= 1'b0;
                        state_q    <= RESYNC;
                    end else begin
                        if (i_ABORT) rq1_n_q <= 1'b0;
`ifdef STOPREQ_WATCHDOG_EN
                        if (sup.i_ROT8[ROT8_LAP_SLOT]) begin
                            if (lap_q == LAP_W'(TIMEOUT_LAPS - 1)) begin
                                timeout_q  <= 1'b1;
                                rq0_n_q    <= 1'b1;
                                rq1_n_q    <= 1'b1;
                                seen_low_q <= 1'b0;
                                state_q    <= RESYNC;
                            end else begin
                                lap_q <= lap_q + LAP_W'(1);
                            end
                        end
`endif
                    end
                end
                RESYNC: begin
                    if (!sup.i_SYS_RUN_FLAG) begin
                        seen_low_q <= 1'b1;
                    end else if (seen_low_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sup.o_CLK2M_STOPRQ0_n = rq0_n_q;
    assign sup.o_CLK2M_STOPRQ1_n = rq1_n_q;
    assign o_BUSY                = busy_q;
    assign o_DONE                = done_q;
`ifdef STOPREQ_WATCHDOG_EN
    assign o_TIMEOUT             = timeout_q;
`else
    assign o_TIMEOUT             = 1'b0;
`endif

endmodule

// File: tb/tb_mdl_stopreq_seq.sv
// tb/tb_mdl_stopreq_seq.sv - directed bench for mdl_stopreq_seq; watchdog case follows STOPREQ_WATCHDOG_EN
module tb_mdl_stopreq_seq;
    import mdl_stopreq_seq_pkg::*;

    logic       i_MCLK = 1'b0;
    logic       i_MRST_n = 1'b0;
    logic       i_CLK4M_PCEN_n = 1'b0;
    logic       i_START = 1'b0;
    logic [7:0] i_FRAMES = 8'd0;
    logic       i_ABORT = 1'b0;
    logic       o_BUSY, o_DONE, o_TIMEOUT;

    mdl_stopreq_seq_if sup_if();

    mdl_stopreq_seq #(.FRAME_W(8), .TIMEOUT_LAPS(4)) dut (
        .i_MCLK         (i_MCLK),
        .i_MRST_n       (i_MRST_n),
        .i_CLK4M_PCEN_n (i_CLK4M_PCEN_n),
        .sup            (sup_if),
        .i_START        (i_START),
        .i_FRAMES       (i_FRAMES),
        .i_ABORT        (i_ABORT),
        .o_BUSY         (o_BUSY),
        .o_DONE         (o_DONE),
        .o_TIMEOUT      (o_TIMEOUT)
    );

    always #5 i_MCLK = ~i_MCLK;

    int n_chk = 0;
    int n_err = 0;
    int r8 = 0;
    int r20 = 0;
    logic wrap_edge, lap_edge;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic apply_rot();
        sup_if.i_ROT8    = 8'(1 << r8);
        sup_if.i_ROT20_n = ~20'(1 << r20);
    endtask

    // One master clock; the bench-side rotators step only on enabled edges.
    task automatic cyc();
        wrap_edge = !i_CLK4M_PCEN_n && !sup_if.i_CLK2M_PCEN_n && (r20 == ROT20_LAST_SLOT);
        lap_edge  = !i_CLK4M_PCEN_n && (r8 == ROT8_LAP_SLOT);
        @(posedge i_MCLK);
        #1;
        if (!i_CLK4M_PCEN_n) begin
            r8  = (r8 + 1) % 8;
            r20 = (r20 + 1) % 20;
            apply_rot();
        end
    endtask

    task automatic start_seq(input logic [7:0] frames);
        i_FRAMES = frames;
        i_START  = 1'b1;
        cyc();
        i_START  = 1'b0;
    endtask

    task automatic finish_seq(input string tag, input bit do_stop);
        if (do_stop) begin
            sup_if.i_CLK2M_STOP_n = 1'b0;
            cyc();
            chk({tag, "_rel0"}, sup_if.o_CLK2M_STOPRQ0_n, 1);
            chk({tag, "_rel1"}, sup_if.o_CLK2M_STOPRQ1_n, 1);
        end
        sup_if.i_SYS_RUN_FLAG = 1'b0;
        cyc();
        sup_if.i_CLK2M_STOP_n = 1'b1;
        chk({tag, "_nodone_low"}, o_DONE, 0);
        chk({tag, "_busy_resync"}, o_BUSY, 1);
        sup_if.i_SYS_RUN_FLAG = 1'b1;
        cyc();
        chk({tag, "_done"}, o_DONE, 1);
        cyc();
        chk({tag, "_done_once"}, o_DONE, 0);
        chk({tag, "_idle"}, o_BUSY, 0);
    endtask

    initial begin
        int wraps;
        int laps;
        sup_if.i_CLK2M_STOP_n = 1'b1;
        sup_if.i_SYS_RUN_FLAG = 1'b1;
        sup_if.i_CLK2M_PCEN_n = 1'b0;
        apply_rot();
        repeat (3) cyc();
        chk("rst_rq0", sup_if.o_CLK2M_STOPRQ0_n, 1);
        chk("rst_rq1", sup_if.o_CLK2M_STOPRQ1_n, 1);
        chk("rst_busy", o_BUSY, 0);
        chk("rst_done", o_DONE, 0);
        chk("rst_timeout", o_TIMEOUT, 0);
        i_MRST_n = 1'b1;
        cyc();

        // Three frames, normal stop.
        start_seq(8'd3);
        chk("f3_busy", o_BUSY, 1);
        wraps = 0;
        for (int i = 0; i < 200 && sup_if.o_CLK2M_STOPRQ0_n; i++) begin
            cyc();
            if (wrap_edge) wraps++;
        end
        chk("f3_rq0", sup_if.o_CLK2M_STOPRQ0_n, 0);
        chk("f3_wraps", wraps, 3);
        chk("f3_on_wrap", wrap_edge, 1);
        chk("f3_rq1", sup_if.o_CLK2M_STOPRQ1_n, 1);
        finish_seq("f3", 1);

        // Disabled edges hold everything, including a start.
        i_CLK4M_PCEN_n = 1'b1;
        i_START = 1'b1;
        repeat (3) cyc();
        i_START = 1'b0;
        chk("hold_busy", o_BUSY, 0);
        i_CLK4M_PCEN_n = 1'b0;
        cyc();

        // Zero frames means 256 wraps.
        start_seq(8'd0);
        wraps = 0;
        for (int i = 0; i < 8000 && sup_if.o_CLK2M_STOPRQ0_n; i++) begin
            cyc();
            if (wrap_edge) wraps++;
        end
        chk("f0_rq0", sup_if.o_CLK2M_STOPRQ0_n, 0);
        chk("f0_wraps", wraps, 256);
        finish_seq("f0", 1);

        // Abort after one of five frames.
        start_seq(8'd5);
        wraps = 0;
        for (int i = 0; i < 200 && wraps < 1; i++) begin
            cyc();
            if (wrap_edge) wraps++;
        end
        chk("ab_one_wrap", wraps, 1);
        i_ABORT = 1'b1;
        cyc();
        i_ABORT = 1'b0;
        chk("ab_rq1", sup_if.o_CLK2M_STOPRQ1_n, 0);
        chk("ab_rq0", sup_if.o_CLK2M_STOPRQ0_n, 1);
        repeat (5) cyc();
        chk("ab_rq1_hold", sup_if.o_CLK2M_STOPRQ1_n, 0);
        finish_seq("ab", 1);

        // Abort coinciding with the final wrap.
        start_seq(8'd1);
        for (int i = 0; i < 40 && r20 != ROT20_LAST_SLOT; i++) cyc();
        i_ABORT = 1'b1;
        cyc();
        i_ABORT = 1'b0;
        chk("pr_was_wrap", wrap_edge, 1);
        chk("pr_rq1", sup_if.o_CLK2M_STOPRQ1_n, 0);
        chk("pr_rq0", sup_if.o_CLK2M_STOPRQ0_n, 1);
        finish_seq("pr", 1);

        // Start is ignored while the run flag is low.
        sup_if.i_SYS_RUN_FLAG = 1'b0;
        start_seq(8'd1);
        sup_if.i_SYS_RUN_FLAG = 1'b1;
        chk("nr_busy", o_BUSY, 0);
        repeat (30) cyc();
        chk("nr_rq0", sup_if.o_CLK2M_STOPRQ0_n, 1);
        chk("nr_busy_late", o_BUSY, 0);

`ifdef STOPREQ_WATCHDOG_EN
        start_seq(8'd1);
        for (int i = 0; i < 60 && sup_if.o_CLK2M_STOPRQ0_n; i++) cyc();
        chk("wd_rq0", sup_if.o_CLK2M_STOPRQ0_n, 0);
        laps = 0;
        for (int i = 0; i < 100 && !o_TIMEOUT; i++) begin
            cyc();
            if (lap_edge) laps++;
        end
        chk("wd_timeout", o_TIMEOUT, 1);
        chk("wd_laps", laps, 4);
        chk("wd_rel0", sup_if.o_CLK2M_STOPRQ0_n, 1);
        finish_seq("wd", 0);
        chk("wd_sticky", o_TIMEOUT, 1);
        start_seq(8'd5);
        chk("wd_clear", o_TIMEOUT, 0);
        i_ABORT = 1'b1;
        cyc();
        i_ABORT = 1'b0;
        finish_seq("wd2", 1);
`else
        start_seq(8'd1);
        for (int i = 0; i < 60 && sup_if.o_CLK2M_STOPRQ0_n; i++) cyc();
        chk("nowd_rq0", sup_if.o_CLK2M_STOPRQ0_n, 0);
        laps = 0;
        for (int i = 0; i < 48; i++) begin
            cyc();
            if (lap_edge) laps++;
        end
        chk("nowd_laps", laps, 6);
        chk("nowd_timeout", o_TIMEOUT, 0);
        chk("nowd_rq0_held", sup_if.o_CLK2M_STOPRQ0_n, 0);
        finish_seq("nowd", 1);
`endif

        // Async reset in STOPRQ releases outputs without a clock edge.
        start_seq(8'd5);
        i_ABORT = 1'b1;
        cyc();
        i_ABORT = 1'b0;
        chk("ar_pre_rq1", sup_if.o_CLK2M_STOPRQ1_n, 0);
        #2;
        i_MRST_n = 1'b0;
        #1;
        chk("ar_rq0", sup_if.o_CLK2M_STOPRQ0_n, 1);
        chk("ar_rq1", sup_if.o_CLK2M_STOPRQ1_n, 1);
        chk("ar_busy", o_BUSY, 0);
        #1;
        i_MRST_n = 1'b1;
        cyc();
        chk("ar_after_busy", o_BUSY, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
